axil_master: RTL and testbench

AXIL_MASTER -- requirements
Module: axil_master

---
 rtl/axil_master.sv | 170 +++++++++++++++++
 tb/tb_axil_master.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_master.sv
// axil_master: single-outstanding AXI4-Lite master driven by a simple
// command/response handshake. Writes issue AW and W together, reads issue AR;
// the response (BRESP or RDATA/RRESP) is held on the rsp_* port until consumed.
module axil_master (
  input  logic        clk,
  input  logic        rst,
  // command side
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  // response side
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_we,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  // write address channel
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  // write data channel
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  // write response channel
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  // read address channel
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  // read data channel
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RSP} state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  wstrb_reg, wstrb_next;
  logic        awvalid_reg, awvalid_next;
  logic        wvalid_reg, wvalid_next;
  logic        arvalid_reg, arvalid_next;
  logic        rsp_we_reg, rsp_we_next;
  logic [31:0] rsp_rdata_reg, rsp_rdata_next;
  logic [1:0]  rsp_resp_reg, rsp_resp_next;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Captured command, AXI VALID flags and response holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      rsp_we_reg    <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_resp_reg  <= '0;
    end else begin
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      wstrb_reg     <= wstrb_next;
      awvalid_reg   <= awvalid_next;
      wvalid_reg    <= wvalid_next;
      arvalid_reg   <= arvalid_next;
      rsp_we_reg    <= rsp_we_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_resp_reg  <= rsp_resp_next;
    end
  end

  // Next-state and next-register logic; VALIDs only ever react to READYs
  // through a register, so no VALID depends combinationally on a READY.
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    wstrb_next     = wstrb_reg;
    awvalid_next   = awvalid_reg;
    wvalid_next    = wvalid_reg;
    arvalid_next   = arvalid_reg;
    rsp_we_next    = rsp_we_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_resp_next  = rsp_resp_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          // Word-align once at capture so AW/AR simply present the register.
          addr_next = cmd_addr & 32'hFFFF_FFFC;
          if (cmd_we) begin
            wdata_next   = cmd_wdata;
            wstrb_next   = cmd_wstrb;
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            state_next   = WADDR;
          end else begin
            arvalid_next = 1'b1;
            state_next   = RADDR;
          end
        end
      end
      WADDR: begin
        // AW and W retire independently; a low VALID here means already done.
        if (awvalid_reg && M_AXI_AWREADY) awvalid_next = 1'b0;
        if (wvalid_reg && M_AXI_WREADY)   wvalid_next  = 1'b0;
        if ((!awvalid_reg || M_AXI_AWREADY) && (!wvalid_reg || M_AXI_WREADY))
          state_next = WRESP;
      end
      WRESP: begin
        if (M_AXI_BVALID) begin
          rsp_resp_next  = M_AXI_BRESP;
          rsp_rdata_next = '0;
          rsp_we_next    = 1'b1;
          state_next     = RSP;
        end
      end
      RADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_next = 1'b0;
          state_next   = RDATA;
        end
      end
      RDATA: begin
        if (M_AXI_RVALID) begin
          rsp_resp_next  = M_AXI_RRESP;
          rsp_rdata_next = M_AXI_RDATA;
          rsp_we_next    = 1'b0;
          state_next     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign cmd_ready     = (state_reg == IDLE);
  assign rsp_valid     = (state_reg == RSP);
  assign rsp_we        = rsp_we_reg;
  assign rsp_rdata     = rsp_rdata_reg;
  assign rsp_resp      = rsp_resp_reg;

  assign M_AXI_AWADDR  = addr_reg;
  assign M_AXI_AWVALID = awvalid_reg;
  assign M_AXI_WDATA   = wdata_reg;
  assign M_AXI_WSTRB   = wstrb_reg;
  assign M_AXI_WVALID  = wvalid_reg;
  assign M_AXI_BREADY  = (state_reg == WRESP);
  assign M_AXI_ARADDR  = addr_reg;
  assign M_AXI_ARVALID = arvalid_reg;
  assign M_AXI_RREADY  = (state_reg == RDATA);

endmodule

// File: tb/tb_axil_master.sv
// tb_axil_master: directed stimulus for axil_master. The stimulus process
// plays the AXI slave cycle by cycle and checks channel signals; expected
// responses go into a queue that a separate monitor drains on rsp handshakes.
module tb_axil_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_we;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;

  typedef struct packed {
    logic        we;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  axil_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    step();
    cmd_valid = 1'b0;
    $display("cmd we=%0d addr=0x%08h wdata=0x%08h strb=0x%h", we, a, d, s);
  endtask

  task automatic expect_rsp(input logic we, input logic [31:0] d, input logic [1:0] r);
    rsp_t e;
    e.we = we; e.rdata = d; e.resp = r;
    exp_q.push_back(e);
  endtask

  // Monitor: every response handshake is compared against the queue head.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got we=%0d rdata=0x%08h resp=%0d expected none",
                 rsp_we, rsp_rdata, rsp_resp);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_we", {31'd0, rsp_we}, {31'd0, e.we});
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_resp", {30'd0, rsp_resp}, {30'd0, e.resp});
        $display("rsp we=%0d rdata=0x%08h resp=%0d", rsp_we, rsp_rdata, rsp_resp);
      end
    end
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;

    // Reset state
    step(); step();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_valids", {29'd0, awvalid, wvalid, arvalid}, 32'd0);
    chk("rst_readys", {30'd0, bready, rready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_awaddr", awaddr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    step();

    // Minimum-latency write, all READYs high
    awready = 1'b1; wready = 1'b1; rsp_ready = 1'b1;
    expect_rsp(1'b1, 32'd0, 2'b00);
    issue(1'b1, 32'h000, 32'h0000_0002, 4'hF);
    chk("w1_awvalid", {31'd0, awvalid}, 32'd1);
    chk("w1_wvalid", {31'd0, wvalid}, 32'd1);
    chk("w1_awaddr", awaddr, 32'h000);
    chk("w1_wdata", wdata, 32'h2);
    chk("w1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    step();
    chk("w1_valids_drop", {30'd0, awvalid, wvalid}, 32'd0);
    chk("w1_bready", {31'd0, bready}, 32'd1);
    bvalid = 1'b1; bresp = 2'b00;
    step();
    bvalid = 1'b0;
    chk("w1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("w1_bready_low", {31'd0, bready}, 32'd0);
    step();
    chk("w1_idle", {31'd0, cmd_ready}, 32'd1);
    chk("w1_rsp_gone", {31'd0, rsp_valid}, 32'd0);

    // Write with AW accepted three cycles before W, unaligned address
    awready = 1'b1; wready = 1'b0;
    expect_rsp(1'b1, 32'd0, 2'b01);
    issue(1'b1, 32'h013, 32'hDEAD_BEEF, 4'hF);
    chk("w2_awaddr", awaddr, 32'h010);
    chk("w2_both_valid", {30'd0, awvalid, wvalid}, 32'd3);
    step();
    awready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("w2_aw_dropped", {31'd0, awvalid}, 32'd0);
      chk("w2_w_held", {31'd0, wvalid}, 32'd1);
      chk("w2_wdata_stable", wdata, 32'hDEAD_BEEF);
      chk("w2_no_bready", {31'd0, bready}, 32'd0);
      if (i == 2) wready = 1'b1;
      step();
    end
    wready = 1'b0;
    chk("w2_w_dropped", {31'd0, wvalid}, 32'd0);
    chk("w2_bready", {31'd0, bready}, 32'd1);
    bvalid = 1'b1; bresp = 2'b01;
    step();
    bvalid = 1'b0;
    chk("w2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    step();

    // Read with ARREADY delayed two cycles
    arready = 1'b0;
    expect_rsp(1'b0, 32'h1234_5678, 2'b00);
    issue(1'b0, 32'h010, 32'h0, 4'h0);
    for (int i = 0; i < 2; i++) begin
      chk("r1_arvalid", {31'd0, arvalid}, 32'd1);
      chk("r1_araddr", araddr, 32'h010);
      chk("r1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("r1_no_rready", {31'd0, rready}, 32'd0);
      step();
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("r1_ar_dropped", {31'd0, arvalid}, 32'd0);
    chk("r1_rready", {31'd0, rready}, 32'd1);
    chk("r1_cmd_ready2", {31'd0, cmd_ready}, 32'd0);
    rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00;
    step();
    rvalid = 1'b0; rdata = '0;
    chk("r1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("r1_cmd_ready3", {31'd0, cmd_ready}, 32'd0);
    step();

    // Read with SLVERR and rsp_ready held off five cycles
    rsp_ready = 1'b0; arready = 1'b1;
    expect_rsp(1'b0, 32'hCAFE_0001, 2'b10);
    issue(1'b0, 32'h020, 32'h0, 4'h0);
    step();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hCAFE_0001; rresp = 2'b10;
    step();
    rvalid = 1'b0; rdata = '0; rresp = '0;
    for (int i = 0; i < 5; i++) begin
      chk("r2_rsp_held", {31'd0, rsp_valid}, 32'd1);
      chk("r2_resp_held", {30'd0, rsp_resp}, 32'd2);
      chk("r2_rdata_held", rsp_rdata, 32'hCAFE_0001);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("r2_idle", {31'd0, cmd_ready}, 32'd1);
    chk("r2_rsp_gone", {31'd0, rsp_valid}, 32'd0);

    // Spurious BVALID in IDLE, then during RADDR
    bvalid = 1'b1; bresp = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sp_idle_no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("sp_idle_ready", {31'd0, cmd_ready}, 32'd1);
    end
    expect_rsp(1'b0, 32'h0BAD_F00D, 2'b00);
    issue(1'b0, 32'h044, 32'h0, 4'h0);
    for (int i = 0; i < 2; i++) begin
      chk("sp_raddr_no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("sp_raddr_arvalid", {31'd0, arvalid}, 32'd1);
      chk("sp_raddr_no_bready", {31'd0, bready}, 32'd0);
      step();
    end
    bvalid = 1'b0; bresp = '0;
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h0BAD_F00D; rresp = 2'b00;
    step();
    rvalid = 1'b0; rdata = '0;
    step();

    // Reset in WADDR with AWVALID high
    awready = 1'b0; wready = 1'b0;
    issue(1'b1, 32'h080, 32'h5555_AAAA, 4'hF);
    chk("rw_awvalid_before", {31'd0, awvalid}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rw_valids", {29'd0, awvalid, wvalid, arvalid}, 32'd0);
    chk("rw_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rw_bready", {31'd0, bready}, 32'd0);
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rw_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    bvalid = 1'b0;

    // Write after reset recovery, partial strobes
    expect_rsp(1'b1, 32'd0, 2'b00);
    issue(1'b1, 32'h106, 32'h0000_A5A5, 4'h3);
    chk("w3_awaddr", awaddr, 32'h104);
    chk("w3_wstrb", {28'd0, wstrb}, 32'h3);
    step();
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    chk("w3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    step(); step();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
